// File: rtl/fp32_mul_round_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_round_pack_if
// Brief    : Handshake bundle for the binary32 multiplier round/pack stage
// Revision : 1.0
// ============================================================================
interface fp32_mul_round_pack_if #(
   parameter int EXP_W = 10
);
   logic             in_valid;
   logic             in_ready;
   logic [47:0]      prod;
   logic             sign;
   logic [EXP_W-1:0] exp_sum;
   logic [2:0]       rm;
   logic             in_nan;
   logic             in_inf;
   logic             in_zero;
   logic             in_nv;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      result;
   logic [4:0]       fflags;

   modport master (
      output in_valid, prod, sign, exp_sum, rm, in_nan, in_inf, in_zero, in_nv, out_ready,
      input  in_ready, out_valid, result, fflags
   );

   modport slave (
      input  in_valid, prod, sign, exp_sum, rm, in_nan, in_inf, in_zero, in_nv, out_ready,
      output in_ready, out_valid, result, fflags
   );
endinterface
`default_nettype wire

// File: rtl/fp32_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_round_pack
// Brief    : Normalise, denormalise, round and pack a binary32 product (2 stages)
// Revision : 1.0
// ============================================================================
module fp32_mul_round_pack #(
   parameter int          EXP_W     = 10,
   parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
   input wire                    clk,
   input wire                    rst_n,
   fp32_mul_round_pack_if.slave  bus
);
   localparam int         EW     = EXP_W + 1;
   localparam logic [4:0] MAX_SH = 5'd26;

   logic          s2_adv;

   logic          r1_valid;
   logic [23:0]   r1_mant;
   logic          r1_g;
   logic          r1_s;
   logic [EW-1:0] r1_e;
   logic          r1_sign;
   logic [2:0]    r1_rm;
   logic          r1_nan;
   logic          r1_inf;
   logic          r1_zero;
   logic          r1_nv;

   logic          r2_valid;
   logic [31:0]   r_result;
   logic [4:0]    r_fflags;

   logic [23:0]   w_mant;
   logic          w_g;
   logic          w_s;
   logic [EW-1:0] w_e;
   logic          w_tiny;
   logic [EW-1:0] w_sh_raw;
   logic [4:0]    w_sh;
   logic [50:0]   w_wide;
   logic [23:0]   w_mant_dn;
   logic          w_g_dn;
   logic          w_s_dn;
   logic [EW-1:0] w_e_dn;

   logic          w_inc;
   logic          w_to_inf;
   logic [24:0]   w_sum;
   logic [22:0]   w_frac;
   logic [EW-1:0] w_e_f;
   logic          w_inexact;
   logic          w_ovf;
   logic [31:0]   w_result;
   logic [4:0]    w_flags;

   assign s2_adv       = !r2_valid || bus.out_ready;
   assign bus.in_ready = !r1_valid || s2_adv;

   // Stage 1: normalise on the product MSB, then shift right into the subnormal range
   always_comb begin
      if (bus.prod[47]) begin
         w_mant = bus.prod[47:24];
         w_g    = bus.prod[23];
         w_s    = |bus.prod[22:0];
      end else begin
         w_mant = bus.prod[46:23];
         w_g    = bus.prod[22];
         w_s    = |bus.prod[21:0];
      end
      w_e      = {bus.exp_sum[EXP_W-1], bus.exp_sum} + EW'(bus.prod[47]);
      w_tiny   = w_e[EW-1] || (w_e == '0);
      w_sh_raw = EW'(1) - w_e;
      w_sh     = (w_sh_raw > EW'(MAX_SH)) ? MAX_SH : w_sh_raw[4:0];
      // 26 guard zeros below {mant,G} keep every shifted-out bit visible for sticky
      w_wide   = {w_mant, w_g, 26'b0} >> w_sh;
      if (w_tiny) begin
         w_mant_dn = w_wide[50:27];
         w_g_dn    = w_wide[26];
         w_s_dn    = w_s | (|w_wide[25:0]);
         w_e_dn    = '0;
      end else begin
         w_mant_dn = w_mant;
         w_g_dn    = w_g;
         w_s_dn    = w_s;
         w_e_dn    = w_e;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_mant  <= '0;
         r1_g     <= 1'b0;
         r1_s     <= 1'b0;
         r1_e     <= '0;
         r1_sign  <= 1'b0;
         r1_rm    <= '0;
         r1_nan   <= 1'b0;
         r1_inf   <= 1'b0;
         r1_zero  <= 1'b0;
         r1_nv    <= 1'b0;
      end else if (bus.in_ready) begin
         r1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r1_mant <= w_mant_dn;
            r1_g    <= w_g_dn;
            r1_s    <= w_s_dn;
            r1_e    <= w_e_dn;
            r1_sign <= bus.sign;
            r1_rm   <= bus.rm;
            r1_nan  <= bus.in_nan;
            r1_inf  <= bus.in_inf;
            r1_zero <= bus.in_zero;
            r1_nv   <= bus.in_nv;
         end
      end
   end

   // Stage 2: round, fix up exponent on carry, then overflow and special override
   always_comb begin
      case (r1_rm)
         3'd1:    w_inc = 1'b0;
         3'd2:    w_inc = r1_sign & (r1_g | r1_s);
         3'd3:    w_inc = ~r1_sign & (r1_g | r1_s);
         3'd4:    w_inc = r1_g;
         default: w_inc = r1_g & (r1_s | r1_mant[0]);
      endcase
      case (r1_rm)
         3'd1:    w_to_inf = 1'b0;
         3'd2:    w_to_inf = r1_sign;
         3'd3:    w_to_inf = ~r1_sign;
         default: w_to_inf = 1'b1;
      endcase
      w_sum = {1'b0, r1_mant} + 25'(w_inc);
      if (w_sum[24]) begin
         w_frac = 23'h0;
         w_e_f  = r1_e + EW'(1);
      end else begin
         w_frac = w_sum[22:0];
         // a subnormal that rounds into the hidden bit becomes the minimum normal
         w_e_f  = ((r1_e == '0) && w_sum[23]) ? EW'(1) : r1_e;
      end
      w_inexact = r1_g | r1_s;
      w_ovf     = (w_e_f >= EW'(255));
      w_result  = {r1_sign, w_e_f[7:0], w_frac};
      w_flags   = {3'b000, (w_e_f == '0) & w_inexact, w_inexact};
      if (w_ovf) begin
         w_result = w_to_inf ? {r1_sign, 8'hFF, 23'h0} : {r1_sign, 8'hFE, 23'h7FFFFF};
         w_flags  = 5'b00101;
      end
      if (r1_nan) begin
         w_result = CANON_NAN;
         w_flags  = {r1_nv, 4'b0000};
      end else if (r1_inf) begin
         w_result = {r1_sign, 8'hFF, 23'h0};
         w_flags  = {r1_nv, 4'b0000};
      end else if (r1_zero) begin
         w_result = {r1_sign, 31'h0};
         w_flags  = {r1_nv, 4'b0000};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
         r_result <= '0;
         r_fflags <= '0;
      end else if (s2_adv) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r_result <= w_result;
            r_fflags <= w_flags;
         end
      end
   end

   assign bus.out_valid = r2_valid;
   assign bus.result    = r_result;
   assign bus.fflags    = r_fflags;
endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_mul_round_pack
// Brief    : Self-checking bench: directed table, pipeline corner cases, random vs model
// Revision : 1.0
// ============================================================================
module tb_fp32_mul_round_pack;
   localparam int EXP_W = 10;

   typedef struct {
      logic [47:0]             prod;
      logic                    sign;
      logic signed [EXP_W-1:0] exp_sum;
      logic [2:0]              rm;
      logic                    nan;
      logic                    inf;
      logic                    zero;
      logic                    nv;
      logic [31:0]             res;
      logic [4:0]              flg;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp32_mul_round_pack_if #(.EXP_W(EXP_W)) bus ();

   fp32_mul_round_pack #(
      .EXP_W     (EXP_W),
      .CANON_NAN (32'h7FC00000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t  expq[$];
   int    n_vec  = 0;
   int    n_fail = 0;
   int    n_out  = 0;
   bit    rand_rdy = 1'b0;
   vec_t  tbl[20];
   vec_t  v;
   int    n0;
   logic [31:0] snap_res;
   logic [4:0]  snap_flg;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [47:0] p, input logic s, input int es,
                               input logic [2:0] rm, input logic [3:0] sp,
                               input logic [31:0] res, input logic [4:0] flg);
      vec_t r;
      r.prod = p;  r.sign = s;  r.exp_sum = es[EXP_W-1:0];  r.rm = rm;
      r.nan = sp[3];  r.inf = sp[2];  r.zero = sp[1];  r.nv = sp[0];
      r.res = res;  r.flg = flg;
      return r;
   endfunction

   // Exact value is prod * 2^(exp_sum-173); round it onto the binary32 grid
   function automatic vec_t ref_model(input vec_t vi);
      vec_t r;
      int p, k, q, sh, field;
      longint unsigned n, rem, half;
      bit gt, eq, nz, up, to_inf;
      r = vi;
      if (vi.nan) begin
         r.res = 32'h7FC00000;  r.flg = {vi.nv, 4'b0};  return r;
      end
      if (vi.inf) begin
         r.res = {vi.sign, 8'hFF, 23'h0};  r.flg = {vi.nv, 4'b0};  return r;
      end
      if (vi.zero) begin
         r.res = {vi.sign, 31'h0};  r.flg = {vi.nv, 4'b0};  return r;
      end
      p = 47;
      while (p > 0 && vi.prod[p] == 1'b0) p--;
      k  = int'(vi.exp_sum) - 173;
      q  = (((p + k) > -126) ? (p + k) : -126) - 23;
      sh = q - k;
      if (sh > 50) begin
         n = 0;  gt = 1'b0;  eq = 1'b0;  nz = (vi.prod != 0);
      end else begin
         n    = 64'(vi.prod) >> sh;
         rem  = 64'(vi.prod) - (n << sh);
         half = 64'd1 << (sh - 1);
         gt   = rem > half;  eq = rem == half;  nz = rem != 0;
      end
      case (vi.rm)
         3'd1:    up = 1'b0;
         3'd2:    up = vi.sign && nz;
         3'd3:    up = !vi.sign && nz;
         3'd4:    up = gt || eq;
         default: up = gt || (eq && n[0]);
      endcase
      n = n + 64'(up);
      if (n == (64'd1 << 24)) begin
         n = 64'd1 << 23;  q++;
      end
      field = q + 149 + int'(n >> 23);
      if (field >= 255) begin
         to_inf = (vi.rm == 3'd1) ? 1'b0 : (vi.rm == 3'd2) ? vi.sign :
                  (vi.rm == 3'd3) ? !vi.sign : 1'b1;
         r.res  = to_inf ? {vi.sign, 8'hFF, 23'h0} : {vi.sign, 8'hFE, 23'h7FFFFF};
         r.flg  = 5'b00101;
      end else begin
         r.res  = {vi.sign, 8'(field), n[22:0]};
         r.flg  = {3'b000, (field == 0) && nz, nz};
      end
      return r;
   endfunction

   task automatic send(input vec_t vi, input bit push);
      bit   acc;
      exp_t e;
      bus.prod = vi.prod;  bus.sign = vi.sign;  bus.exp_sum = vi.exp_sum;  bus.rm = vi.rm;
      bus.in_nan = vi.nan;  bus.in_inf = vi.inf;  bus.in_zero = vi.zero;  bus.in_nv = vi.nv;
      bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.in_ready;
         if (acc && push) begin
            e.res = vi.res;  e.flg = vi.flg;
            expq.push_back(e);
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 100 && expq.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      if (expq.size() != 0) check("drain_timeout", 64'(expq.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_out++;
         if (expq.size() == 0) begin
            check("unexpected_out", 64'd1, 64'd0);
         end else begin
            e = expq.pop_front();
            check("result", 64'(bus.result), 64'(e.res));
            check("fflags", 64'(bus.fflags), 64'(e.flg));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = mk(48'h9000_0000_0000, 0, 127, 3'd0, 4'b0000, 32'h40100000, 5'b00000);
      tbl[1]  = mk(48'h4000_0040_0000, 0, 127, 3'd0, 4'b0000, 32'h3F800000, 5'b00001);
      tbl[2]  = mk(48'h4000_0040_0000, 0, 127, 3'd3, 4'b0000, 32'h3F800001, 5'b00001);
      tbl[3]  = mk(48'h4000_0040_0000, 0, 127, 3'd4, 4'b0000, 32'h3F800001, 5'b00001);
      tbl[4]  = mk(48'h4000_0040_0000, 0, 127, 3'd1, 4'b0000, 32'h3F800000, 5'b00001);
      tbl[5]  = mk(48'h4000_0040_0000, 0, 127, 3'd5, 4'b0000, 32'h3F800000, 5'b00001);
      tbl[6]  = mk(48'h8000_0000_0000, 0, 300, 3'd0, 4'b0000, 32'h7F800000, 5'b00101);
      tbl[7]  = mk(48'h8000_0000_0000, 0, 300, 3'd1, 4'b0000, 32'h7F7FFFFF, 5'b00101);
      tbl[8]  = mk(48'h8000_0000_0000, 1, 300, 3'd2, 4'b0000, 32'hFF800000, 5'b00101);
      tbl[9]  = mk(48'h8000_0000_0000, 1, 300, 3'd3, 4'b0000, 32'hFF7FFFFF, 5'b00101);
      tbl[10] = mk(48'h8000_0000_0000, 0, -30, 3'd0, 4'b0000, 32'h00000000, 5'b00011);
      tbl[11] = mk(48'h8000_0000_0000, 0, -30, 3'd3, 4'b0000, 32'h00000001, 5'b00011);
      tbl[12] = mk(48'h8000_0000_0000, 0, 0,   3'd0, 4'b0000, 32'h00800000, 5'b00000);
      tbl[13] = mk(48'hFFFF_FF80_0000, 0, -1,  3'd0, 4'b0000, 32'h00800000, 5'b00001);
      tbl[14] = mk(48'hFFFF_FFC0_0000, 0, 127, 3'd0, 4'b0000, 32'h40800000, 5'b00001);
      tbl[15] = mk(48'h1234_5678_9ABC, 0, 127, 3'd0, 4'b1101, 32'h7FC00000, 5'b10000);
      tbl[16] = mk(48'h8000_0000_0000, 1, 127, 3'd0, 4'b0110, 32'hFF800000, 5'b00000);
      tbl[17] = mk(48'h0000_0000_0000, 1, 127, 3'd0, 4'b0010, 32'h80000000, 5'b00000);
      tbl[18] = mk(48'h8000_0000_0000, 1, -30, 3'd2, 4'b0000, 32'h80000001, 5'b00011);
      tbl[19] = mk(48'h8000_0000_0000, 0, -5,  3'd0, 4'b0000, 32'h00040000, 5'b00000);

      rst_n = 1'b0;
      bus.in_valid = 1'b0;  bus.out_ready = 1'b0;  bus.prod = '0;  bus.sign = 1'b0;
      bus.exp_sum = '0;  bus.rm = '0;  bus.in_nan = 1'b0;  bus.in_inf = 1'b0;
      bus.in_zero = 1'b0;  bus.in_nv = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_result",    64'(bus.result),    64'd0);
      check("reset_fflags",    64'(bus.fflags),    64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Latency: out_valid appears two cycles after the beat is presented
      send(tbl[0], 1'b1);
      check("latency_early", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check("latency_valid", 64'(bus.out_valid), 64'd1);
      drain();

      for (int i = 0; i < 20; i++) send(tbl[i], 1'b1);
      drain();

      // Backpressure: stall output, fill both stages, third beat must wait
      bus.out_ready = 1'b0;
      v = tbl[1];  send(v, 1'b1);
      v = tbl[6];  send(v, 1'b1);
      check("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
      check("bp_out_valid",    64'(bus.out_valid), 64'd1);
      snap_res = bus.result;
      snap_flg = bus.fflags;
      n0 = n_out;
      fork
         send(tbl[14], 1'b1);
         begin
            repeat (4) @(posedge clk);
            #1;
            check("bp_hold_result", 64'(bus.result),   64'(snap_res));
            check("bp_hold_fflags", 64'(bus.fflags),   64'(snap_flg));
            check("bp_still_stall", 64'(bus.in_ready), 64'd0);
            check("bp_no_output",   64'(n_out),        64'(n0));
            bus.out_ready = 1'b1;
            for (int k = 1; k <= 3; k++) begin
               @(posedge clk); #1;
               check("bp_one_per_cycle", 64'(n_out), 64'(n0 + k));
            end
         end
      join
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [23:0] ma, mb;
         int es;
         ma = 24'($urandom_range(0, 24'hFFFFFF)) | 24'h800000;
         mb = ($urandom_range(0, 3) == 0) ? 24'h800000 : (24'($urandom_range(0, 24'hFFFFFF)) | 24'h800000);
         case ($urandom_range(0, 4))
            0:       es = int'($urandom_range(1, 250));
            1:       es = int'($urandom_range(240, 270));
            2:       es = int'($urandom_range(0, 40)) - 35;
            3:       es = int'($urandom_range(0, 1023)) - 512;
            default: es = int'($urandom_range(0, 8)) - 4;
         endcase
         v = mk(48'(ma) * 48'(mb), 1'($urandom_range(0, 1)), es, 3'($urandom_range(0, 7)),
                4'b0000, 32'h0, 5'h0);
         if ($urandom_range(0, 15) == 0) begin
            v.nan = 1'($urandom_range(0, 1));  v.inf  = 1'($urandom_range(0, 1));
            v.zero = 1'($urandom_range(0, 1)); v.nv   = 1'($urandom_range(0, 1));
         end
         v = ref_model(v);
         send(v, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
         end
      end
      rand_rdy = 1'b0;
      drain();

      // Reset with both stages full: nothing may emerge afterwards
      bus.out_ready = 1'b0;
      send(tbl[0], 1'b0);
      send(tbl[12], 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid_async", 64'(bus.out_valid), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      n0 = n_out;
      repeat (6) @(posedge clk);
      #1;
      check("rst_no_stale_beat", 64'(n_out),         64'(n0));
      check("rst_out_valid",     64'(bus.out_valid), 64'd0);
      check("rst_result",        64'(bus.result),    64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fp32_mul_round_pack.md
Name: fp32_mul_round_pack

Overview:
- Downstream stage of the single-precision multiplier datapath in the RISCV32F FPU.
- Consumes the 48-bit mantissa product, the result sign and the pre-normalisation exponent.
- Normalises, denormalises when tiny, rounds per RISC-V rm and packs an IEEE-754 binary32 result plus fflags.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
EXP_W, 10, width of signed two's-complement exponent input (biased: ea+eb-127)
CANON_NAN, 32'h7FC00000, value packed for any NaN result

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  stage can accept input
prod  input  48  unsigned 24x24 mantissa product (hidden bits included)
sign  input  1  result sign (sa^sb)
exp_sum  input  EXP_W  signed biased exponent before normalisation
rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
in_nan  input  1  result is NaN
in_inf  input  1  result is infinity
in_zero  input  1  result is zero
in_nv  input  1  invalid operation (sNaN operand or inf*0)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  packed binary32
fflags  output  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset: all internal valids, out_valid, result and fflags clear to 0. Reset asynchronous, active-low; in-flight beats dropped, none emitted after release.
- Handshake:
  - Beat accepted when in_valid&&in_ready.
  - S2 advances when !out_valid||out_ready.
  - S1 advances when S2 advances.
  - in_ready = !s1_valid || S2 advances.
  - result/fflags held stable while out_valid&&!out_ready.
  - In-order, no loss or duplication.
- Latency: 2 cycles from accept to out_valid with out_ready held high. Throughput: 1 per cycle.
- Stage 1, normalise:
  - If prod[47]: mant=prod[47:24], G=prod[23], S=|prod[22:0], e=exp_sum+1.
  - Else: mant=prod[46:23], G=prod[22], S=|prod[21:0], e=exp_sum.
- Stage 1, denormalise (e<=0):
  - Shift {mant,G} right by 1-e, capped at 26.
  - All shifted-out bits OR into S; e=0.
- Stage 2, round: inc decided from L=mant[0], G, S, sign.
  - RNE: G&(S|L).
  - RTZ: 0.
  - RDN: sign&(G|S).
  - RUP: !sign&(G|S).
  - RMM: G.
  - rm 5..7 treated as RNE.
- Stage 2, pack: mant+inc.
  - Carry out of 24 bits: mant=1<<23, e+1.
  - Subnormal rounding into hidden bit: exponent field becomes 1.
- Overflow (e>=255 after rounding): OF|NX.
  - Result is infinity for RNE, RMM, RDN with sign=1, and RUP with sign=0.
  - Otherwise result is max finite {sign,8'hFE,23'h7FFFFF}.
- NX: G|S, or overflow.
- UF: final exponent field 0 and NX. Rounding up to min normal is not tiny.
- Specials (priority nan > inf > zero; flags other than NV cleared):
  - nan: CANON_NAN, NV=in_nv.
  - inf: {sign,8'hFF,0}.
  - zero: {sign,31'b0}.
- DZ always 0.
- exp_sum very negative (below -30): result is signed zero or min subnormal per rm, UF|NX set.

Test Plan:
- 1.5*1.5: prod=48'h9000_0000_0000, exp_sum=127, sign 0, RNE -> result 32'h40100000, fflags 0, out_valid exactly 2 cycles after accept.
- Tie: prod=48'h4000_0040_0000, exp_sum=127, sign 0 -> RNE 32'h3F800000, RUP 32'h3F800001, RMM 32'h3F800001; all fflags 5'b00001.
- Overflow: prod=48'h8000_0000_0000, exp_sum=300, sign 0 -> RNE 32'h7F800000 fflags 5'b00101; RTZ 32'h7F7FFFFF fflags 5'b00101.
- Underflow: prod=48'h8000_0000_0000, exp_sum=-30, sign 0 -> RNE 32'h00000000 fflags 5'b00011; RUP 32'h00000001 fflags 5'b00011. exp_sum=0 -> 32'h00800000, fflags 0.
- Backpressure: out_ready=0, drive 3 back-to-back beats -> in_ready drops after 2nd accept, outputs frozen. Raise out_ready -> 3 results in order, one per cycle.
- Special/reset: in_nan=1, in_nv=1 -> 32'h7FC00000, fflags 5'b10000. Assert rst_n=0 with both stages full -> out_valid=0 immediately, no stale beat after release.
